// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg
// Shared types and helpers for the multi-read-port register file.
//   clr_state_e : bulk-clear sequencer states
//   RF_ZERO     : index of the optional hardwired-zero register
//   rf_clog2    : ceil(log2(n)), used to derive the address width
package regfile_mp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int RF_ZERO = 0;

  function automatic int rf_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if
// Bus bundle between the datapath (decode/writeback) and the register file.
//   we, wa, wd : write port (enable, address, data)
//   ra         : packed read addresses, port i = ra[i*AW +: AW]
//   rd         : packed read data,      port i = rd[i*WIDTH +: WIDTH]
//   clr_req    : bulk-clear request (pulse or level)
//   busy       : clear sequencer running
//   wr_ok      : write presented this cycle is accepted
// Modports: master = datapath side, slave = register file side.
interface regfile_mp_if #(
  parameter int WIDTH  = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2
) ();

  logic                    we;
  logic [AW-1:0]           wa;
  logic [WIDTH-1:0]        wd;
  logic [NUM_RD*AW-1:0]    ra;
  logic [NUM_RD*WIDTH-1:0] rd;
  logic                    clr_req;
  logic                    busy;
  logic                    wr_ok;

  modport master (
    output we, wa, wd, ra, clr_req,
    input  rd, busy, wr_ok
  );

  modport slave (
    input  we, wa, wd, ra, clr_req,
    output rd, busy, wr_ok
  );

endinterface

// File: rtl/regfile_mp_clr_seq.sv
// regfile_mp_clr_seq
// Bulk-clear sequencer: walks every register address once, one per cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr_req    : start request, only honoured in IDLE
//   busy       : sequencer running (forced low while rst_n=0)
//   clr_we     : clear write strobe for the top-level write mux
//   clr_addr   : address being cleared this cycle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; clr_req starts a clear from address 0
// CLEAR | zeroing mem[cnt] each cycle; leaves after address DEPTH-1
module regfile_mp_clr_seq
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Gated with rst_n so busy is low throughout reset, even before the
  // first reset edge has initialised the state register.
  assign busy     = rst_n & (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised register file: one clocked write port, NUM_RD asynchronous
// read ports, optional hardwired-zero register 0, hardware bulk clear.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset (clears all registers)
//   bus   : regfile_mp_if slave modport (we/wa/wd, ra/rd, clr_req/busy/wr_ok)
// Configuration macro REGFILE_MP_BYPASS_EN: when defined, a write accepted
// this cycle is forwarded to any read port addressing the same register.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = rf_clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             busy;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_ok;
  logic             wa_is_zero;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  regfile_mp_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_ok      = rst_n & bus.we & ~busy;
  assign wa_is_zero = HAS_ZERO && (bus.wa == AW'(RF_ZERO));
  assign bus.busy   = busy;
  assign bus.wr_ok  = wr_ok;

  // Clear has priority; in practice the two never overlap because user
  // writes are refused whenever the sequencer is busy.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.wa;
    wr_data = bus.wd;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (wr_ok && !wa_is_zero) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef REGFILE_MP_BYPASS_EN
  logic fwd_en;
  assign fwd_en = wr_ok & ~wa_is_zero;
`endif

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;

    assign addr = bus.ra[p*AW +: AW];

    always_comb begin
      data = mem[addr];
      if (HAS_ZERO && addr == AW'(RF_ZERO)) data = '0;
`ifdef REGFILE_MP_BYPASS_EN
      if (fwd_en && bus.wa == addr) data = bus.wd;
`endif
    end

    assign bus.rd[p*WIDTH +: WIDTH] = data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_mp_if #(.WIDTH(32), .AW(5), .NUM_RD(4)) bus ();
  regfile_mp_if #(.WIDTH(32), .AW(5), .NUM_RD(2)) bus_nz ();

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(4), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0)) dut_nz (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic [4:0]      wa;
    logic [31:0]     wd;
    logic [3:0][4:0] ra;
    logic [3:0][31:0] rd;
    logic            wr_ok;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mkv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [4:0] a3,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3,
                               input logic ok);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.ra = {a3, a2, a1, a0};
    v.rd = {e3, e2, e1, e0};
    v.wr_ok = ok;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rdp(input int p);
    return bus.rd[p*32 +: 32];
  endfunction

  // Reads every register through the four ports; expects zero except one.
  task automatic check_all(input string tag, input int sp_addr, input logic [31:0] sp_val);
    logic [31:0] exp;
    for (int a = 0; a < 32; a += 4) begin
      @(negedge clk);
      bus.ra = {5'(a + 3), 5'(a + 2), 5'(a + 1), 5'(a)};
      #1;
      for (int p = 0; p < 4; p++) begin
        exp = (a + p == sp_addr) ? sp_val : 32'h0;
        chk($sformatf("%s_r%0d", tag, a + p), rdp(p), exp);
      end
    end
    chk({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
  endtask

  task automatic fill_all(input logic [31:0] val);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      bus.we = 1'b1;
      bus.wa = 5'(a);
      bus.wd = val;
    end
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  initial begin
    int  n;
    bit  done;
    checks = 0;
    errors = 0;

    vecs[0] = mkv(1, 5,  32'hDEADBEEF, 1, 2, 3, 4,   0, 0, 0, 0, 1);
    vecs[1] = mkv(1, 1,  32'd1,        5, 0, 0, 0,   32'hDEADBEEF, 0, 0, 0, 1);
    vecs[2] = mkv(1, 2,  32'd2,        1, 5, 0, 1,   1, 32'hDEADBEEF, 0, 1, 1);
    vecs[3] = mkv(1, 3,  32'd3,        2, 1, 5, 2,   2, 1, 32'hDEADBEEF, 2, 1);
    vecs[4] = mkv(1, 4,  32'd4,        3, 3, 3, 3,   3, 3, 3, 3, 1);
    vecs[5] = mkv(1, 0,  32'h1234,     4, 3, 2, 1,   4, 3, 2, 1, 1);
    vecs[6] = mkv(0, 0,  32'h0,        0, 1, 2, 3,   0, 1, 2, 3, 0);
    vecs[7] = mkv(1, 31, 32'h80000001, 30, 0, 4, 5,  0, 0, 4, 32'hDEADBEEF, 1);
    vecs[8] = mkv(0, 31, 32'hFFFFFFFF, 31, 31, 30, 0, 32'h80000001, 32'h80000001, 0, 0, 0);
    vecs[9] = mkv(0, 0,  32'h0,        31, 4, 1, 2,  32'h80000001, 4, 1, 2, 0);

    // Reset with a write attempt held on the bus.
    rst_n = 1'b0;
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h12345678; bus.ra = '0; bus.clr_req = 1'b0;
    bus_nz.we = 1'b0; bus_nz.wa = '0; bus_nz.wd = '0; bus_nz.ra = '0; bus_nz.clr_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_wr_ok", {31'h0, bus.wr_ok}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.we = 1'b0;
    check_all("reset", -1, 32'h0);

    // Table vectors: inputs applied, combinational reads checked, then commit.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.we = vecs[i].we;
      bus.wa = vecs[i].wa;
      bus.wd = vecs[i].wd;
      bus.ra = vecs[i].ra;
      #1;
      for (int p = 0; p < 4; p++)
        chk($sformatf("vec%0d_rd%0d", i, p), rdp(p), vecs[i].rd[p]);
      chk($sformatf("vec%0d_wr_ok", i), {31'h0, bus.wr_ok}, {31'h0, vecs[i].wr_ok});
      chk($sformatf("vec%0d_busy", i), {31'h0, bus.busy}, 32'h0);
    end
    @(negedge clk);
    bus.we = 1'b0;

    // ZERO_REG=0 instance: register 0 is ordinary.
    @(negedge clk);
    bus_nz.we = 1'b1; bus_nz.wa = 5'd0; bus_nz.wd = 32'h1234; bus_nz.ra = '0;
    #1;
    chk("nz_wr_ok", {31'h0, bus_nz.wr_ok}, 32'h1);
    chk("nz_same_cycle", bus_nz.rd[31:0], BYP ? 32'h1234 : 32'h0);
    @(negedge clk);
    bus_nz.we = 1'b0;
    #1;
    chk("nz_r0_p0", bus_nz.rd[31:0], 32'h1234);
    chk("nz_r0_p1", bus_nz.rd[63:32], 32'h1234);

    // Bulk clear with a dropped write and an ignored re-request.
    fill_all(32'hFFFFFFFF);
    @(negedge clk);
    bus.clr_req = 1'b1;
    bus.we = 1'b1; bus.wa = 5'd31; bus.wd = 32'h31;
    #1;
    chk("clr_req_wr_ok", {31'h0, bus.wr_ok}, 32'h1);
    chk("clr_req_busy", {31'h0, bus.busy}, 32'h0);
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (!bus.busy) begin
        done = 1'b1;
      end else begin
        bus.clr_req = (n == 15);
        bus.we = (n == 10);
        bus.wa = 5'd2;
        bus.wd = 32'h77;
        bus.ra = {5'd0, 5'd0, 5'd20, 5'd5};
        #1;
        if (n == 10) begin
          chk("clear_wr_ok", {31'h0, bus.wr_ok}, 32'h0);
          chk("clear_rd_done", rdp(0), 32'h0);
          chk("clear_rd_pending", rdp(1), 32'hFFFFFFFF);
        end
        n++;
      end
    end
    bus.we = 1'b0;
    bus.clr_req = 1'b0;
    chk("clear_len", 32'(n), 32'd32);
    check_all("after_clear", -1, 32'h0);

    // Reset in the middle of a clear.
    fill_all(32'hFFFFFFFF);
    @(negedge clk);
    bus.clr_req = 1'b1;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      bus.clr_req = 1'b0;
      if (!bus.busy) begin
        done = 1'b1;
      end else if (n == 7) begin
        rst_n = 1'b0;
        bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'hBAD;
        #1;
        chk("midclr_rst_wr_ok", {31'h0, bus.wr_ok}, 32'h0);
        done = 1'b1;
      end else begin
        n++;
      end
    end
    chk("midclr_reach", 32'(n), 32'd7);
    @(negedge clk);
    rst_n = 1'b1;
    bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h9999;
    #1;
    chk("midclr_busy_next", {31'h0, bus.busy}, 32'h0);
    chk("midclr_new_wr_ok", {31'h0, bus.wr_ok}, 32'h1);
    @(negedge clk);
    bus.we = 1'b0;
    check_all("midclr", 9, 32'h9999);

    // Write-then-read in the same cycle.
    @(negedge clk);
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h11111111;
    @(negedge clk);
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'hA5A5A5A5;
    bus.ra = {5'd0, 5'd9, 5'd7, 5'd7};
    #1;
    chk("byp_p0", rdp(0), BYP ? 32'hA5A5A5A5 : 32'h11111111);
    chk("byp_p1", rdp(1), BYP ? 32'hA5A5A5A5 : 32'h11111111);
    chk("byp_p2", rdp(2), 32'h9999);
    chk("byp_p3", rdp(3), 32'h0);
    @(negedge clk);
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF;
    bus.ra = {5'd0, 5'd0, 5'd0, 5'd7};
    #1;
    chk("byp_next", rdp(0), 32'hA5A5A5A5);
    chk("byp_zero", rdp(1), 32'h0);
    @(negedge clk);
    bus.we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
